fault_inject_layer_bus: RTL and testbench

- Parametrised, transaction-aware fault injector inserted between two NN layers on the flattened layer-output bus (LANES lanes x LANE_W bits).
- Adds stuck-at-0, stuck-at-1 and bit-flip modes on any selectable lane.
- Supports a programmable trigger delay and fault duration, counted in valid beats.
- Registered pass-through with a per-beat corruption flag and a saturating injection counter, for error-resilience campaigns.

---
 rtl/fault_inject_layer_bus_if.sv | 22 ++
 rtl/fault_inject_layer_bus.sv | 148 ++++++++++++++
 tb/tb_fault_inject_layer_bus.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fault_inject_layer_bus_if.sv
// Layer-output bus between two NN layers: beat qualifier, flattened lane data
// and the injector's corruption flag on the downstream side.
interface fault_inject_layer_bus_if #(
    parameter int LANES  = 32,
    parameter int LANE_W = 20
);
    logic                    valid_in;
    logic [LANES*LANE_W-1:0] data_in;
    logic                    valid_out;
    logic [LANES*LANE_W-1:0] data_out;
    logic                    corrupt_out;

    modport master (
        output valid_in, data_in,
        input  valid_out, data_out, corrupt_out
    );

    modport slave (
        input  valid_in, data_in,
        output valid_out, data_out, corrupt_out
    );
endinterface

// File: rtl/fault_inject_layer_bus.sv
// Transaction-aware fault injector on a flattened NN layer bus: stuck-at / flip on
// one lane, gated by beat-counted trigger delay and duration, one-cycle latency.
module fault_inject_layer_bus #(
    parameter int LANES  = 32,
    parameter int LANE_W = 20,
    parameter int CNT_W  = 32,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_enable,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [1:0]           cfg_mode,
    input  logic [LW-1:0]        cfg_lane,
    input  logic [LANE_W-1:0]    cfg_mask,
    input  logic [CNT_W-1:0]     cfg_delay,
    input  logic [CNT_W-1:0]     cfg_duration,
    fault_inject_layer_bus_if.slave bus,
    output logic                 fault_active,
    output logic                 fault_done,
    output logic [CNT_W-1:0]     inject_count
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [LW-1:0]           r_lane;
    logic [LANE_W-1:0]       r_mask;
    logic [CNT_W-1:0]        r_dcnt;
    logic [CNT_W-1:0]        r_rcnt;
    logic [CNT_W-1:0]        r_inj;
    logic                    r_valid;
    logic                    r_corrupt;
    logic [LANES*LANE_W-1:0] r_data;

    logic                    w_beat;
    logic                    w_elig;
    logic                    w_lane_ok;
    logic                    w_arm_ok;
    logic [LANES-1:0]        w_hit;
    logic [LANES*LANE_W-1:0] w_data_mod;

    function automatic logic [LANE_W-1:0] f_corrupt(input logic [1:0] m,
                                                   input logic [LANE_W-1:0] d,
                                                   input logic [LANE_W-1:0] mk);
        case (m)
            2'd1:    f_corrupt = d & ~mk;
            2'd2:    f_corrupt = d | mk;
            2'd3:    f_corrupt = d ^ mk;
            default: f_corrupt = d;
        endcase
    endfunction

    // Out-of-range lanes only exist when LANES is not a power of two.
    generate
        if ((1 << LW) > LANES) begin : g_lchk
            assign w_lane_ok = (int'(cfg_lane) < LANES);
        end else begin : g_lall
            assign w_lane_ok = 1'b1;
        end
    endgenerate

    assign w_beat   = bus.valid_in;
    assign w_arm_ok = arm && (cfg_mode != 2'd0) && w_lane_ok;
    assign w_elig   = w_beat && clk_enable &&
                      (((r_state == S_ARMED) && (r_dcnt == '0)) || (r_state == S_ACTIVE));

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_hit[k] = w_elig && (r_lane == LW'(k));
            assign w_data_mod[k*LANE_W +: LANE_W] = w_hit[k]
                ? f_corrupt(r_mode, bus.data_in[k*LANE_W +: LANE_W], r_mask)
                : bus.data_in[k*LANE_W +: LANE_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_lane  <= '0;
            r_mask  <= '0;
            r_dcnt  <= '0;
            r_rcnt  <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_arm_ok) begin
                        r_state <= S_ARMED;
                        r_mode  <= cfg_mode;
                        r_lane  <= cfg_lane;
                        r_mask  <= cfg_mask;
                        r_dcnt  <= cfg_delay;
                        r_rcnt  <= cfg_duration;
                    end else if (arm) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (w_beat && clk_enable) begin
                        if (r_dcnt != '0) begin
                            r_dcnt <= r_dcnt - ONE;
                        end else if (r_rcnt == ONE) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ACTIVE;
                            if (r_rcnt != '0) r_rcnt <= r_rcnt - ONE;
                        end
                    end
                end
                S_ACTIVE: begin
                    // rcnt==0 is the permanent mode and never counts down.
                    if (w_beat && clk_enable) begin
                        if (r_rcnt == ONE)     r_state <= S_DONE;
                        else if (r_rcnt != '0) r_rcnt  <= r_rcnt - ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_corrupt <= 1'b0;
            r_data    <= '0;
            r_inj     <= '0;
        end else begin
            r_valid   <= w_beat;
            r_corrupt <= w_elig;
            if (w_beat) r_data <= w_data_mod;
            if (w_elig && !(&r_inj)) r_inj <= r_inj + ONE;
        end
    end

    assign bus.valid_out   = r_valid;
    assign bus.data_out    = r_data;
    assign bus.corrupt_out = r_corrupt;
    assign inject_count    = r_inj;
    assign fault_active    = (r_state == S_ARMED) || (r_state == S_ACTIVE);
    assign fault_done      = (r_state == S_DONE);
endmodule

// File: tb/tb_fault_inject_layer_bus.sv
// Directed bench for fault_inject_layer_bus: expected beats are queued at issue time
// and a forked monitor pops and compares them whenever valid_out is seen.
module tb_fault_inject_layer_bus;
    localparam int LANES  = 32;
    localparam int LANE_W = 20;
    localparam int CNT_W  = 5;
    localparam int W      = LANES * LANE_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_enable = 1'b1;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       cfg_mode = '0;
    logic [4:0]       cfg_lane = '0;
    logic [19:0]      cfg_mask = '0;
    logic [CNT_W-1:0] cfg_delay = '0;
    logic [CNT_W-1:0] cfg_duration = '0;
    logic             fault_active;
    logic             fault_done;
    logic [CNT_W-1:0] inject_count;

    fault_inject_layer_bus_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

    fault_inject_layer_bus #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .arm(arm), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_lane(cfg_lane), .cfg_mask(cfg_mask),
        .cfg_delay(cfg_delay), .cfg_duration(cfg_duration), .bus(bus.slave),
        .fault_active(fault_active), .fault_done(fault_done), .inject_count(inject_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] d; logic c; } exp_t;
    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int base);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[l*LANE_W +: LANE_W] = LANE_W'(base + l);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic [W-1:0] e, input logic c);
        exp_t x;
        x.d = e;
        x.c = c;
        q.push_back(x);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        tick();
        bus.valid_in = 1'b0;
    endtask

    // Config is scrambled right after the arm to show only the armed values matter.
    task automatic do_arm(input logic [1:0] m, input logic [4:0] l, input logic [19:0] mk,
                          input logic [CNT_W-1:0] dl, input logic [CNT_W-1:0] du);
        cfg_mode = m; cfg_lane = l; cfg_mask = mk; cfg_delay = dl; cfg_duration = du;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cfg_mode = 2'd1; cfg_lane = 5'd9; cfg_mask = 20'h5A5A5; cfg_delay = 5'd7; cfg_duration = 5'd1;
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat act=%h exp=none", bus.data_out);
                end else begin
                    x = q.pop_front();
                    chk("data_out", bus.data_out, x.d);
                    chk("corrupt_out", W'(bus.corrupt_out), W'(x.c));
                end
            end
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] lane31_ones;
        logic [W-1:0] lane5_ones;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        lane31_ones  = W'(20'hFFFFF) << 620;
        lane5_ones   = W'(20'hFFFFF) << 100;
        fork monitor(); join_none

        // reset state
        tick(); tick();
        chk("rst_valid_out", W'(bus.valid_out), W'(1'b0));
        chk("rst_data_out", bus.data_out, '0);
        chk("rst_corrupt", W'(bus.corrupt_out), W'(1'b0));
        chk("rst_active", W'(fault_active), W'(1'b0));
        chk("rst_done", W'(fault_done), W'(1'b0));
        chk("rst_count", W'(inject_count), W'(0));
        rst = 1'b0;

        // pass-through, never armed
        for (int i = 0; i < 10; i++) beat(pat(i * 40), pat(i * 40), 1'b0);
        tick();
        chk("pt_count", W'(inject_count), W'(0));

        // flip lane0 bit0, delay 2, duration 3
        do_arm(2'd3, 5'd0, 20'h00001, 5'd2, 5'd3);
        chk("dd_active", W'(fault_active), W'(1'b1));
        for (int b = 0; b < 7; b++) begin
            d = pat(100 + b * 32);
            if (b >= 2 && b <= 4) beat(d, d ^ W'(1), 1'b1);
            else                  beat(d, d, 1'b0);
            if (b == 3) chk("dd_done_b3", W'(fault_done), W'(1'b0));
            if (b == 4) chk("dd_done_b4", W'(fault_done), W'(1'b1));
        end
        chk("dd_count", W'(inject_count), W'(3));

        // SA1 permanent on last lane, re-armed from DONE
        do_arm(2'd2, 5'd31, 20'hFFFFF, 5'd0, 5'd0);
        for (int b = 0; b < 5; b++) beat('0, lane31_ones, 1'b1);
        chk("sa_active", W'(fault_active), W'(1'b1));
        chk("sa_done", W'(fault_done), W'(1'b0));
        chk("sa_count", W'(inject_count), W'(8));
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle", W'(fault_active | fault_done), W'(1'b0));

        // SA0 lane5, delay 1, duration 2, enable low on beats 1-2
        do_arm(2'd1, 5'd5, 20'hFFFFF, 5'd1, 5'd2);
        for (int b = 1; b <= 6; b++) begin
            clk_enable = (b > 2);
            if (b == 4 || b == 5) beat('1, ~lane5_ones, 1'b1);
            else                  beat('1, '1, 1'b0);
            if (b == 2) chk("ce_frozen_active", W'(fault_active), W'(1'b1));
        end
        clk_enable = 1'b1;
        chk("ce_done", W'(fault_done), W'(1'b1));
        chk("ce_count", W'(inject_count), W'(10));

        // invalid arm from DONE -> IDLE, invalid arm from IDLE stays IDLE
        do_arm(2'd0, 5'd3, 20'hFFFFF, 5'd0, 5'd0);
        chk("inv_done_to_idle", W'({fault_active, fault_done}), W'(2'b00));
        do_arm(2'd0, 5'd3, 20'hFFFFF, 5'd0, 5'd0);
        chk("inv_idle_stays", W'({fault_active, fault_done}), W'(2'b00));
        beat(pat(7), pat(7), 1'b0);

        // overlapping arm while ACTIVE is ignored
        do_arm(2'd3, 5'd2, 20'h000F0, 5'd0, 5'd0);
        d = pat(500);
        beat(d, d ^ (W'(20'h000F0) << 40), 1'b1);
        do_arm(2'd1, 5'd7, 20'hFFFFF, 5'd0, 5'd0);
        d = pat(600);
        beat(d, d ^ (W'(20'h000F0) << 40), 1'b1);
        chk("ovl_count", W'(inject_count), W'(12));

        // abort beats arm in the same cycle
        cfg_mode = 2'd2; cfg_lane = 5'd1; cfg_mask = 20'h1; cfg_delay = '0; cfg_duration = '0;
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        chk("abort_arm_idle", W'({fault_active, fault_done}), W'(2'b00));
        beat(pat(900), pat(900), 1'b0);

        // reset mid-fault
        do_arm(2'd2, 5'd0, 20'h00001, 5'd0, 5'd0);
        beat('0, W'(1), 1'b1);
        chk("mid_active", W'(fault_active), W'(1'b1));
        rst = 1'b1; tick();
        chk("mr_valid_out", W'(bus.valid_out), W'(1'b0));
        chk("mr_data_out", bus.data_out, '0);
        chk("mr_corrupt", W'(bus.corrupt_out), W'(1'b0));
        chk("mr_state", W'({fault_active, fault_done}), W'(2'b00));
        chk("mr_count", W'(inject_count), W'(0));
        rst = 1'b0;
        beat('0, '0, 1'b0);

        // saturation of the 5-bit injection counter
        do_arm(2'd3, 5'd1, 20'h00001, 5'd0, 5'd0);
        for (int b = 0; b < 34; b++) begin
            d = pat(b * 64);
            beat(d, d ^ (W'(1) << 20), 1'b1);
            if (b == 30) chk("sat_reach", W'(inject_count), W'(31));
        end
        chk("sat_hold", W'(inject_count), W'(31));
        chk("sat_active", W'(fault_active), W'(1'b1));

        tick(); tick();
        chk("sb_empty", W'(q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
